// File: rtl/ext_mem_responder.sv
// ext_mem_responder: word-addressed external memory model for the DMA read port.
// Fixed-latency single-word reads, independent single-cycle write port.
module ext_mem_responder #(
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_request_extmem,
  input  logic [31:0] addr_extmem,
  output logic        r_valid_extmem,
  output logic [31:0] data_extmem,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        oob_err,
  output logic [15:0] rd_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    VALID
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic        load;
  logic        rd_fire;
  logic [31:0] rd_addr;
  logic        rd_oob;
  logic        wr_oob;
  logic [31:0] rd_word;
  logic [31:0] mem [DEPTH];

  // With READ_LAT==1 the array is read on the accepting edge,
  // before addr_q holds the address, so read straight from the port.
  assign rd_addr = load ? addr_extmem : addr_q;
  assign rd_oob  = |rd_addr[31:ADDR_W];
  assign wr_oob  = |wr_addr[31:ADDR_W];

  assign r_valid_extmem = (state_q == VALID);
  assign busy           = (state_q != IDLE);

  // Read FSM: next state, latency counter and address capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    rd_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (r_request_extmem) begin
          load  = 1'b1;
          cnt_d = LAT_M1;
          if (READ_LAT == 1) begin
            state_d = VALID;
            rd_fire = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!r_request_extmem) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = VALID;
          rd_fire = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      VALID: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read data source: out-of-range reads give 0, same-edge write wins
  always_comb begin
    rd_word = mem[rd_addr[ADDR_W-1:0]];
    if (rd_oob) begin
      rd_word = 32'd0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      rd_word = wr_data;
    end
  end

  // FSM state, counter and captured address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        addr_q <= addr_extmem;
      end
    end
  end

  // Response data register, sticky range error and read counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_extmem <= 32'd0;
      oob_err     <= 1'b0;
      rd_count    <= 16'd0;
    end else begin
      if (rd_fire) begin
        data_extmem <= rd_word;
      end
      if ((rd_fire && rd_oob) || (wr_en && wr_oob)) begin
        oob_err <= 1'b1;
      end
      if (state_q == VALID) begin
        rd_count <= rd_count + 16'd1;
      end
    end
  end

  // Storage array; not reset, out-of-range writes dropped
  always_ff @(posedge clk) begin
    if (wr_en && !wr_oob) begin
      mem[wr_addr[ADDR_W-1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_ext_mem_responder.sv
// tb_ext_mem_responder: directed bench for ext_mem_responder.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ext_mem_responder;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] data;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        oob;
  logic [15:0] rdc;

  logic        req1;
  logic [31:0] addr1;
  logic        valid1;
  logic [31:0] data1;
  logic        busy1;
  logic        oob1;
  logic [15:0] rdc1;

  int nvec;
  int nerr;

  logic [31:0] pre [7];

  ext_mem_responder #(.ADDR_W(12), .READ_LAT(3)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .r_request_extmem (req),
    .addr_extmem      (addr),
    .r_valid_extmem   (valid),
    .data_extmem      (data),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .busy             (busy),
    .oob_err          (oob),
    .rd_count         (rdc)
  );

  ext_mem_responder #(.ADDR_W(12), .READ_LAT(1)) u_dut1 (
    .clk              (clk),
    .rst              (rst),
    .r_request_extmem (req1),
    .addr_extmem      (addr1),
    .r_valid_extmem   (valid1),
    .data_extmem      (data1),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .busy             (busy1),
    .oob_err          (oob1),
    .rd_count         (rdc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] exp);
    int k;
    req  = 1'b1;
    addr = a;
    k    = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (valid) break;
    end
    check({tag, " lat"}, 32'(k), 32'd3);
    check({tag, " data"}, data, exp);
    req = 1'b0;
    @(negedge clk);
    check({tag, " vld drop"}, {31'd0, valid}, 32'd0);
  endtask

  task automatic collide(input string tag, input int off,
                         input logic [31:0] exp);
    req  = 1'b1;
    addr = 32'h20;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      if (k == 3) begin
        check({tag, " vld"}, {31'd0, valid}, 32'd1);
        check({tag, " data"}, data, exp);
        req = 1'b0;
      end
      if (k == 4) begin
        check({tag, " hold"}, data, exp);
      end
      if (k == off) begin
        wr_en   = 1'b1;
        wr_addr = 32'h20;
        wr_data = 32'h5555_5555;
      end
    end
  endtask

  initial begin
    nvec    = 0;
    nerr    = 0;
    rst     = 1'b1;
    req     = 1'b0;
    addr    = 32'd0;
    req1    = 1'b0;
    addr1   = 32'd0;
    wr_en   = 1'b0;
    wr_addr = 32'd0;
    wr_data = 32'd0;
    pre[0] = 32'h0008_1010;
    pre[1] = 32'h1008_0410;
    pre[2] = 32'h0000_0100;
    pre[3] = 32'h0000_0800;
    pre[4] = 32'h0000_0C00;
    pre[5] = 32'h0000_0D00;
    pre[6] = 32'h0000_0E00;

    @(negedge clk);
    @(negedge clk);
    check("rst valid", {31'd0, valid}, 32'd0);
    check("rst data", data, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst oob", {31'd0, oob}, 32'd0);
    check("rst rdc", {16'd0, rdc}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: preload and seven back-to-back reads
    for (int i = 0; i < 7; i++) wr(32'(i), pre[i]);
    for (int i = 0; i < 7; i++) rd("t1 rd", 32'(i), pre[i]);
    check("t1 rdc", {16'd0, rdc}, 32'd7);

    // Test 2: single-cycle latency instance
    req1  = 1'b1;
    addr1 = 32'd5;
    check("t2 busy pre", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    check("t2 vld", {31'd0, valid1}, 32'd1);
    check("t2 busy", {31'd0, busy1}, 32'd1);
    check("t2 data", data1, 32'h0000_0D00);
    @(negedge clk);
    check("t2 no reacc vld", {31'd0, valid1}, 32'd0);
    check("t2 no reacc busy", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    check("t2 vld2", {31'd0, valid1}, 32'd1);
    req1 = 1'b0;
    @(negedge clk);
    check("t2 rdc", {16'd0, rdc1}, 32'd2);

    // Test 3: read/write collision around the read edge
    wr(32'h20, 32'hAAAA_AAAA);
    collide("t3 same", 3 - 1, 32'h5555_5555);
    wr(32'h20, 32'hAAAA_AAAA);
    collide("t3 early", 1, 32'h5555_5555);
    wr(32'h20, 32'hAAAA_AAAA);
    collide("t3 late", 3, 32'hAAAA_AAAA);
    check("t3 rdc", {16'd0, rdc}, 32'd10);

    // Test 4: abort in WAIT
    req  = 1'b1;
    addr = 32'd4;
    @(negedge clk);
    check("t4 busy wait", {31'd0, busy}, 32'd1);
    req = 1'b0;
    @(negedge clk);
    check("t4 idle", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t4 no vld", {31'd0, valid}, 32'd0);
      @(negedge clk);
    end
    check("t4 rdc", {16'd0, rdc}, 32'd10);
    rd("t4 rd3", 32'd3, 32'h0000_0800);
    check("t4 rdc2", {16'd0, rdc}, 32'd11);

    // Test 5: out-of-range accesses
    check("t5 oob pre", {31'd0, oob}, 32'd0);
    rd("t5 rd oob", 32'h1000, 32'd0);
    check("t5 oob rd", {31'd0, oob}, 32'd1);
    wr(32'h2000, 32'hDEAD_BEEF);
    rd("t5 mem0", 32'd0, 32'h0008_1010);
    check("t5 oob sticky", {31'd0, oob}, 32'd1);

    // Test 6: reset during WAIT
    req  = 1'b1;
    addr = 32'd2;
    @(negedge clk);
    check("t6 busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6 busy rst", {31'd0, busy}, 32'd0);
    check("t6 valid rst", {31'd0, valid}, 32'd0);
    check("t6 data rst", data, 32'd0);
    check("t6 oob rst", {31'd0, oob}, 32'd0);
    check("t6 rdc rst", {16'd0, rdc}, 32'd0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6 no vld", {31'd0, valid}, 32'd0);
    end
    rd("t6 rd2", 32'd2, 32'h0000_0100);
    check("t6 rdc", {16'd0, rdc}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
